// File: rtl/wb_regfile.sv
// Write-back stage: selects the MEM/WB result, commits it to the register file, and keeps a commit trace.
// Optional macro WB_BYPASS_EN makes both read ports write-through for a same-cycle commit.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_write_reg,
  input  logic [DATA_W-1:0] i_write_data,
  input  logic [DATA_W-1:0] i_result,
  input  logic [1:0]        i_WB_control,
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rt_addr,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_commit_vld,
  output logic [ADDR_W-1:0] o_commit_reg,
  output logic [DATA_W-1:0] o_commit_data,
  output logic [CNT_W-1:0]  o_commit_cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              we;

  // i_WB_control[1] = RegWrite, i_WB_control[0] = MemtoReg.
  assign o_wb_data = i_WB_control[0] ? i_write_data : i_result;
  assign we        = i_WB_control[1] && (i_write_reg != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[i_write_reg] <= o_wb_data;
    end
  end

  // o_commit_vld is a one-cycle pulse per committed write; reg/data hold the last commit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_commit_vld  <= 1'b0;
      o_commit_reg  <= '0;
      o_commit_data <= '0;
      o_commit_cnt  <= '0;
    end else begin
      o_commit_vld <= we;
      if (we) begin
        o_commit_reg  <= i_write_reg;
        o_commit_data <= o_wb_data;
        o_commit_cnt  <= o_commit_cnt + CNT_W'(1);
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Write-through: a commit in flight is forwarded to a matching read address.
  always_comb begin
    o_rs_data = regs[i_rs_addr];
    if (i_rs_addr == '0) begin
      o_rs_data = '0;
    end else if (we && (i_rs_addr == i_write_reg)) begin
      o_rs_data = o_wb_data;
    end
  end

  always_comb begin
    o_rt_data = regs[i_rt_addr];
    if (i_rt_addr == '0) begin
      o_rt_data = '0;
    end else if (we && (i_rt_addr == i_write_reg)) begin
      o_rt_data = o_wb_data;
    end
  end
`else
  always_comb begin
    o_rs_data = (i_rs_addr == '0) ? '0 : regs[i_rs_addr];
    o_rt_data = (i_rt_addr == '0) ? '0 : regs[i_rt_addr];
  end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (CNT_W=4 so the counter wrap is reachable).
// Expected read values follow WB_BYPASS_EN when the bench is compiled with it.
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic [DW-1:0] result;
  logic [1:0]    wb_control;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic [DW-1:0] wb_data;
  logic          commit_vld;
  logic [AW-1:0] commit_reg;
  logic [DW-1:0] commit_data;
  logic [CW-1:0] commit_cnt;

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_write_reg  (write_reg),
    .i_write_data (write_data),
    .i_result     (result),
    .i_WB_control (wb_control),
    .i_rs_addr    (rs_addr),
    .i_rt_addr    (rt_addr),
    .o_rs_data    (rs_data),
    .o_rt_data    (rt_data),
    .o_wb_data    (wb_data),
    .o_commit_vld (commit_vld),
    .o_commit_reg (commit_reg),
    .o_commit_data(commit_data),
    .o_commit_cnt (commit_cnt)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard state
  int            tests_run    = 0;
  int            tests_failed = 0;
  logic [DW-1:0] exp_regs [32];
  logic [DW-1:0] exp_q [$];
  logic [CW-1:0] exp_cnt;
  logic [AW-1:0] exp_creg;
  logic [DW-1:0] exp_cdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) exp_regs[i] = '0;
    exp_cnt   = '0;
    exp_creg  = '0;
    exp_cdata = '0;
    exp_q.delete();
  endtask

  // Drives one MEM/WB beat, checks the pre-edge view, then the post-edge state.
  task automatic wb_write(input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                          input logic [DW-1:0] res, input logic [1:0] ctrl,
                          input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                          input string tag);
    logic [DW-1:0] sel;
    logic          we;
    logic [DW-1:0] exp_rs;
    logic [DW-1:0] exp_rt;
    @(negedge clk);
    write_reg  = wr;
    write_data = wd;
    result     = res;
    wb_control = ctrl;
    rs_addr    = ra;
    rt_addr    = rb;
    sel = ctrl[0] ? wd : res;
    we  = ctrl[1] && (wr != '0);
    #1;
    check({tag, "_wbdata"}, wb_data, sel);
    exp_rs = exp_regs[ra];
    exp_rt = exp_regs[rb];
`ifdef WB_BYPASS_EN
    if (we && ra == wr) exp_rs = sel;
    if (we && rb == wr) exp_rt = sel;
`endif
    check({tag, "_pre_rs"}, rs_data, exp_rs);
    check({tag, "_pre_rt"}, rt_data, exp_rt);
    @(posedge clk);
    if (we) begin
      exp_regs[wr] = sel;
      exp_cnt++;
      exp_creg = wr;
      exp_q.push_back(sel);
    end
    #1;
    wb_control = 2'b00;
    if (exp_q.size() != 0) exp_cdata = exp_q.pop_front();
    check({tag, "_vld"}, commit_vld, we);
    check({tag, "_cnt"}, commit_cnt, exp_cnt);
    check({tag, "_creg"}, commit_reg, exp_creg);
    check({tag, "_cdata"}, commit_data, exp_cdata);
    check({tag, "_post_rs"}, rs_data, exp_regs[ra]);
    check({tag, "_post_rt"}, rt_data, exp_regs[rb]);
  endtask

  // Asserts reset between edges and checks that state clears without a clock.
  task automatic reset_mid_run(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    @(negedge clk);
    rs_addr = ra;
    rt_addr = rb;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_rs", rs_data, 32'h0);
    check("rst_rt", rt_data, 32'h0);
    check("rst_cnt", commit_cnt, 32'h0);
    check("rst_vld", commit_vld, 32'h0);
    check("rst_creg", commit_reg, 32'h0);
    check("rst_cdata", commit_data, 32'h0);
    // A write presented while reset is held must be lost.
    write_reg  = 5'd3;
    result     = 32'h0BAD_F00D;
    wb_control = 2'b10;
    @(posedge clk);
    #1;
    check("rst_hold_cnt", commit_cnt, 32'h0);
    @(negedge clk);
    wb_control = 2'b00;
    rst_n      = 1'b1;
    rs_addr    = 5'd3;
    #1;
    check("rst_lost_write", rs_data, 32'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    write_reg  = '0;
    write_data = '0;
    result     = '0;
    wb_control = 2'b00;
    rs_addr    = 5'd5;
    rt_addr    = 5'd7;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_cnt", commit_cnt, 32'h0);
    check("init_vld", commit_vld, 32'h0);
    check("init_rs", rs_data, 32'h0);
    check("init_rt", rt_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    wb_write(5'd5, 32'h0, 32'h1234_5678, 2'b10, 5'd5, 5'd5, "alu");
    check("alu_cnt_is_1", commit_cnt, 32'd1);
    check("alu_rs_value", rs_data, 32'h1234_5678);
    wb_write(5'd7, 32'hDEAD_BEEF, 32'h1, 2'b11, 5'd5, 5'd7, "load");
    check("load_cdata_value", commit_data, 32'hDEAD_BEEF);
    wb_write(5'd0, 32'h0, 32'hFFFF_FFFF, 2'b10, 5'd0, 5'd7, "zero");
    check("zero_cnt_still_2", commit_cnt, 32'd2);
    wb_write(5'd5, 32'hAAAA_0001, 32'hBBBB_0002, 2'b01, 5'd5, 5'd7, "nowr");
    wb_write(5'd9, 32'h0, 32'hA5A5_A5A5, 2'b10, 5'd9, 5'd9, "raw");
    check("raw_after_rs", rs_data, 32'hA5A5_A5A5);

    reset_mid_run(5'd5, 5'd9);

    for (int i = 0; i < 17; i++) begin
      wb_write(5'd1, 32'h0, 32'h100 + i, 2'b10, 5'd1, 5'd0, "wrap");
      if (i == 14) wb_write(5'd1, 32'h0, 32'hCAFE, 2'b00, 5'd1, 5'd1, "wrap_idle");
    end
    check("wrap_end_cnt", commit_cnt, 32'd1);
    check("wrap_end_reg1", rs_data, 32'h110);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
